// File: rtl/alu_seq.sv
// Clocked SM83 ALU: accepts one operation per valid/ready handshake and presents
// the registered result and flags LATENCY cycles later, held until retired.
module alu_seq #(
  parameter int DATA_W  = 8,
  parameter int H_BIT   = 3,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        group,
  input  logic [2:0]        op,
  input  logic [2:0]        bit_idx,
  input  logic [DATA_W-1:0] dest_data,
  input  logic [DATA_W-1:0] src_data,
  input  logic [7:0]        flags_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res,
  output logic [7:0]        flags_res,
  output logic              res_we,
  output logic              flags_we
);

  localparam int W1 = DATA_W + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic              accept;

  logic [1:0]        group_p0;
  logic [2:0]        op_p0;
  logic [2:0]        bit_idx_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [3:0]        f_p0;

  logic [DATA_W:0]   sum;
  logic [7:0]        a8;
  logic [7:0]        r8;
  logic [7:0]        adj;
  logic              cin;
  logic              z;
  logic              n;
  logic              h;
  logic              cy;
  logic [DATA_W-1:0] nres;
  logic              nres_we;
  logic              nflags_we;

  // The low flag nibble of F is architecturally zero and never consulted.
  logic              unused_flags;
  assign unused_flags = ^flags_in[3:0];

  assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // Stage p0: operand capture on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      group_p0   <= group;
      op_p0      <= op;
      bit_idx_p0 <= bit_idx;
      a_p0       <= dest_data;
      b_p0       <= src_data;
      f_p0       <= flags_in[7:4];
    end
  end

  always_comb begin
    a8        = a_p0[7:0];
    r8        = a8;
    adj       = 8'h00;
    cin       = 1'b0;
    sum       = '0;
    z         = f_p0[3];
    n         = f_p0[2];
    h         = f_p0[1];
    cy        = f_p0[0];
    nres      = a_p0;
    nres_we   = 1'b0;
    nflags_we = 1'b0;
    case (group_p0)
      2'b00: begin
        cin = ~op_p0[2] & op_p0[0] & f_p0[0];
        case (op_p0)
          3'd0, 3'd1:       sum = {1'b0, a_p0} + {1'b0, b_p0} + W1'(cin);
          3'd2, 3'd3, 3'd7: sum = {1'b0, a_p0} - {1'b0, b_p0} - W1'(cin);
          default:          sum = '0;
        endcase
        case (op_p0)
          3'd4:    nres = a_p0 & b_p0;
          3'd5:    nres = a_p0 ^ b_p0;
          3'd6:    nres = a_p0 | b_p0;
          default: nres = sum[DATA_W-1:0];
        endcase
        z = (nres == '0);
        case (op_p0)
          3'd4: begin
            n  = 1'b0;
            h  = 1'b1;
            cy = 1'b0;
          end
          3'd5, 3'd6: begin
            n  = 1'b0;
            h  = 1'b0;
            cy = 1'b0;
          end
          default: begin
            // a^b^sum at bit H_BIT+1 recovers the carry/borrow out of bit H_BIT
            n  = op_p0[1];
            h  = a_p0[H_BIT+1] ^ b_p0[H_BIT+1] ^ sum[H_BIT+1];
            cy = sum[DATA_W];
          end
        endcase
        nres_we   = (op_p0 != 3'd7);
        nflags_we = 1'b1;
        if (op_p0 == 3'd7) nres = a_p0;
      end
      2'b01: begin
        case (op_p0[1:0])
          2'b00: begin
            if (!f_p0[2]) begin
              if (f_p0[0] || (a8 > 8'h99)) begin
                adj = 8'h60;
                cy  = 1'b1;
              end
              if (f_p0[1] || (a8[3:0] > 4'h9)) adj = adj | 8'h06;
              r8 = a8 + adj;
            end else begin
              if (f_p0[0]) adj = 8'h60;
              if (f_p0[1]) adj = adj | 8'h06;
              r8 = a8 - adj;
            end
            z       = (r8 == 8'h00);
            h       = 1'b0;
            nres_we = 1'b1;
          end
          2'b01: begin
            r8      = ~a8;
            n       = 1'b1;
            h       = 1'b1;
            nres_we = 1'b1;
          end
          2'b10: begin
            n  = 1'b0;
            h  = 1'b0;
            cy = 1'b1;
          end
          default: begin
            n  = 1'b0;
            h  = 1'b0;
            cy = ~f_p0[0];
          end
        endcase
        nres[7:0] = r8;
        nflags_we = 1'b1;
      end
      2'b10: begin
        case (op_p0)
          3'd0:    begin r8 = {a8[6:0], a8[7]};     cy = a8[7]; end
          3'd1:    begin r8 = {a8[0], a8[7:1]};     cy = a8[0]; end
          3'd2:    begin r8 = {a8[6:0], f_p0[0]};   cy = a8[7]; end
          3'd3:    begin r8 = {f_p0[0], a8[7:1]};   cy = a8[0]; end
          3'd4:    begin r8 = {a8[6:0], 1'b0};      cy = a8[7]; end
          3'd5:    begin r8 = {a8[7], a8[7:1]};     cy = a8[0]; end
          3'd6:    begin r8 = {a8[3:0], a8[7:4]};   cy = 1'b0;  end
          default: begin r8 = {1'b0, a8[7:1]};      cy = a8[0]; end
        endcase
        nres[7:0] = r8;
        z         = (r8 == 8'h00);
        n         = 1'b0;
        h         = 1'b0;
        nres_we   = 1'b1;
        nflags_we = 1'b1;
      end
      default: begin
        case (op_p0[1:0])
          2'b01: begin
            z         = ~a8[bit_idx_p0];
            n         = 1'b0;
            h         = 1'b1;
            nflags_we = 1'b1;
          end
          2'b10: begin
            r8[bit_idx_p0] = 1'b0;
            nres_we        = 1'b1;
          end
          2'b11: begin
            r8[bit_idx_p0] = 1'b1;
            nres_we        = 1'b1;
          end
          default: ;
        endcase
        nres[7:0] = r8;
      end
    endcase
  end

  // Stage p1: control FSM and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      out_valid <= 1'b0;
      res       <= '0;
      flags_res <= 8'h00;
      res_we    <= 1'b0;
      flags_we  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= BUSY;
            cnt   <= 2'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (cnt == 2'd0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            res       <= nres;
            flags_res <= {z, n, h, cy, 4'b0000};
            res_we    <= nres_we;
            flags_we  <= nflags_we;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              state <= BUSY;
              cnt   <= 2'(LATENCY - 1);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: 8-bit instance (LATENCY=2) driven from a vector table through
// a scoreboard queue, plus a 16-bit ADD HL instance (LATENCY=1).
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       in_valid, in_ready, out_valid, out_ready, res_we, flags_we;
  logic [1:0] group;
  logic [2:0] op, bit_idx;
  logic [7:0] dest_data, src_data, flags_in, res, flags_res;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_res_we, w_flags_we;
  logic [1:0]  w_group;
  logic [2:0]  w_op, w_bit_idx;
  logic [15:0] w_dest_data, w_src_data, w_res;
  logic [7:0]  w_flags_in, w_flags_res;

  alu_seq #(.DATA_W(8), .H_BIT(3), .LATENCY(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .group(group), .op(op), .bit_idx(bit_idx), .dest_data(dest_data),
    .src_data(src_data), .flags_in(flags_in), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .flags_res(flags_res),
    .res_we(res_we), .flags_we(flags_we)
  );

  alu_seq #(.DATA_W(16), .H_BIT(11), .LATENCY(1)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .group(w_group), .op(w_op), .bit_idx(w_bit_idx), .dest_data(w_dest_data),
    .src_data(w_src_data), .flags_in(w_flags_in), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .res(w_res), .flags_res(w_flags_res),
    .res_we(w_res_we), .flags_we(w_flags_we)
  );

  typedef struct {
    string      name;
    logic [1:0] group;
    logic [2:0] op;
    logic [2:0] bit_idx;
    logic [7:0] a, b, f;
    logic [7:0] res, flags;
    logic       res_we, flags_we;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [1:0] g, input logic [2:0] o,
                              input logic [2:0] bi, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] f, input logic [7:0] r, input logic [7:0] fl,
                              input logic rw, input logic fw);
    vec_t v;
    v.name = n; v.group = g; v.op = o; v.bit_idx = bi;
    v.a = a; v.b = b; v.f = f; v.res = r; v.flags = fl;
    v.res_we = rw; v.flags_we = fw;
    return v;
  endfunction

  task automatic drive8(input vec_t v);
    group = v.group; op = v.op; bit_idx = v.bit_idx;
    dest_data = v.a; src_data = v.b; flags_in = v.f;
  endtask

  task automatic send8(input vec_t v);
    int t = 0;
    @(negedge clk);
    drive8(v);
    in_valid = 1'b1;
    exp_q.push_back(v);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({v.name, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid8(input string name, input int exp_lat);
    int lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic score8();
    vec_t v;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: output with no expected entry, got res %0h", res);
    end else begin
      v = exp_q.pop_front();
      check({v.name, "_res"},      32'(res),       32'(v.res));
      check({v.name, "_flags"},    32'(flags_res), 32'(v.flags));
      check({v.name, "_res_we"},   32'(res_we),    32'(v.res_we));
      check({v.name, "_flags_we"}, 32'(flags_we),  32'(v.flags_we));
    end
  endtask

  task automatic retire8();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run16(input string name, input logic [1:0] g, input logic [2:0] o,
                       input logic [15:0] a, input logic [15:0] b, input logic [7:0] f,
                       input logic [15:0] er, input logic [7:0] ef);
    int t = 0;
    int lat = 0;
    @(negedge clk);
    w_group = g; w_op = o; w_bit_idx = 3'd0;
    w_dest_data = a; w_src_data = b; w_flags_in = f;
    w_in_valid = 1'b1;
    while (!w_in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!w_out_valid && lat < 20);
    check({name, "_latency"}, 32'(lat), 32'd1);
    check({name, "_res"}, 32'(w_res), 32'(er));
    check({name, "_flags"}, 32'(w_flags_res), 32'(ef));
    w_out_ready = 1'b1;
    @(posedge clk);
    #1 w_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; group = 2'd0; op = 3'd0; bit_idx = 3'd0;
    dest_data = 8'h00; src_data = 8'h00; flags_in = 8'h00;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_group = 2'd0; w_op = 3'd0; w_bit_idx = 3'd0;
    w_dest_data = 16'h0; w_src_data = 16'h0; w_flags_in = 8'h00;

    vecs.push_back(mk("add",       2'd0, 3'd0, 3'd0, 8'h3A, 8'hC6, 8'h00, 8'h00, 8'hB0, 1, 1));
    vecs.push_back(mk("sub",       2'd0, 3'd2, 3'd0, 8'h3E, 8'h3F, 8'h00, 8'hFF, 8'h70, 1, 1));
    vecs.push_back(mk("cp",        2'd0, 3'd7, 3'd0, 8'h3E, 8'h3F, 8'h00, 8'h3E, 8'h70, 0, 1));
    vecs.push_back(mk("adc",       2'd0, 3'd1, 3'd0, 8'h0F, 8'h00, 8'h10, 8'h10, 8'h20, 1, 1));
    vecs.push_back(mk("sbc",       2'd0, 3'd3, 3'd0, 8'h10, 8'h0F, 8'h10, 8'h00, 8'hE0, 1, 1));
    vecs.push_back(mk("sub_wrap",  2'd0, 3'd2, 3'd0, 8'h10, 8'h20, 8'h00, 8'hF0, 8'h50, 1, 1));
    vecs.push_back(mk("add_wrap",  2'd0, 3'd0, 3'd0, 8'h80, 8'h80, 8'h00, 8'h00, 8'h90, 1, 1));
    vecs.push_back(mk("and",       2'd0, 3'd4, 3'd0, 8'hF0, 8'h0F, 8'hF0, 8'h00, 8'hA0, 1, 1));
    vecs.push_back(mk("xor",       2'd0, 3'd5, 3'd0, 8'hFF, 8'h0F, 8'h00, 8'hF0, 8'h00, 1, 1));
    vecs.push_back(mk("or",        2'd0, 3'd6, 3'd0, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h80, 1, 1));
    vecs.push_back(mk("daa_add",   2'd1, 3'd0, 3'd0, 8'h3C, 8'h00, 8'h00, 8'h42, 8'h00, 1, 1));
    vecs.push_back(mk("daa_sub",   2'd1, 3'd0, 3'd0, 8'h0F, 8'h00, 8'h60, 8'h09, 8'h40, 1, 1));
    vecs.push_back(mk("daa_carry", 2'd1, 3'd0, 3'd0, 8'h9A, 8'h00, 8'h00, 8'h00, 8'h90, 1, 1));
    vecs.push_back(mk("cpl",       2'd1, 3'd1, 3'd0, 8'h35, 8'h00, 8'h90, 8'hCA, 8'hF0, 1, 1));
    vecs.push_back(mk("scf",       2'd1, 3'd2, 3'd0, 8'h12, 8'h00, 8'hE0, 8'h12, 8'h90, 0, 1));
    vecs.push_back(mk("ccf",       2'd1, 3'd7, 3'd0, 8'h12, 8'h00, 8'h90, 8'h12, 8'h80, 0, 1));
    vecs.push_back(mk("rlc",       2'd2, 3'd0, 3'd0, 8'h85, 8'h00, 8'h00, 8'h0B, 8'h10, 1, 1));
    vecs.push_back(mk("rrc",       2'd2, 3'd1, 3'd0, 8'h01, 8'h00, 8'h00, 8'h80, 8'h10, 1, 1));
    vecs.push_back(mk("rl",        2'd2, 3'd2, 3'd0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h90, 1, 1));
    vecs.push_back(mk("rr",        2'd2, 3'd3, 3'd0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h90, 1, 1));
    vecs.push_back(mk("sla",       2'd2, 3'd4, 3'd0, 8'h81, 8'h00, 8'h00, 8'h02, 8'h10, 1, 1));
    vecs.push_back(mk("sra",       2'd2, 3'd5, 3'd0, 8'h81, 8'h00, 8'h00, 8'hC0, 8'h10, 1, 1));
    vecs.push_back(mk("swap",      2'd2, 3'd6, 3'd0, 8'hF1, 8'h00, 8'h10, 8'h1F, 8'h00, 1, 1));
    vecs.push_back(mk("srl",       2'd2, 3'd7, 3'd0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h90, 1, 1));
    vecs.push_back(mk("bit7",      2'd3, 3'd1, 3'd7, 8'h7F, 8'h00, 8'h10, 8'h7F, 8'hB0, 0, 1));
    vecs.push_back(mk("bit0",      2'd3, 3'd1, 3'd0, 8'h01, 8'h00, 8'h00, 8'h01, 8'h20, 0, 1));
    vecs.push_back(mk("res3",      2'd3, 3'd6, 3'd3, 8'hFF, 8'h00, 8'hB5, 8'hF7, 8'hB0, 1, 0));
    vecs.push_back(mk("set2",      2'd3, 3'd3, 3'd2, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 1, 0));
    vecs.push_back(mk("reserved",  2'd3, 3'd0, 3'd0, 8'h5A, 8'h00, 8'hC5, 8'h5A, 8'hC0, 0, 0));

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    check("rst_flags", 32'(flags_res), 32'd0);
    check("rst_we", 32'({res_we, flags_we}), 32'd0);
    check("rst_w_out_valid", 32'(w_out_valid), 32'd0);
    rst_n = 1'b1;
    #1 check("rel_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      send8(vecs[i]);
      wait_valid8(vecs[i].name, 2);
      score8();
      retire8();
    end

    // stall with out_ready low, then retire and issue in the same cycle
    send8(vecs[1]);
    wait_valid8("stall", 2);
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_res", 32'(res), 32'h0000_00FF);
      check("stall_flags", 32'(flags_res), 32'h0000_0070);
    end
    score8();
    drive8(vecs[8]);
    exp_q.push_back(vecs[8]);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_busy", 32'(out_valid), 32'd0);
    wait_valid8("b2b", 2);
    score8();
    retire8();

    // asynchronous reset in the middle of BUSY
    send8(vecs[0]);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_res", 32'(res), 32'd0);
    check("midrst_flags", 32'(flags_res), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_rel_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_stale", 32'(seen), 32'd0);
    send8(vecs[13]);
    wait_valid8("post_rst", 2);
    score8();
    retire8();

    // 16-bit ADD HL instance
    run16("w_add_h",   2'd0, 3'd0, 16'h0FFF, 16'h0001, 8'h00, 16'h1000, 8'h20);
    run16("w_add_c",   2'd0, 3'd0, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'hB0);
    run16("w_sub_h",   2'd0, 3'd2, 16'h1000, 16'h0001, 8'h00, 16'h0FFF, 8'h60);
    run16("w_cpl",     2'd1, 3'd1, 16'h1235, 16'h0000, 8'h00, 16'h12CA, 8'h60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
